// File: rtl/aud_pkg.sv
// Shared types for the audio transport controller: FSM state codes and the
// latched playback mode.
package aud_pkg;

    localparam int INIT_PULSE_DEF = 2048;

    typedef enum logic [2:0] {
        ST_INIT       = 3'd0,
        ST_IDLE       = 3'd1,
        ST_RECD       = 3'd2,
        ST_RECD_PAUSE = 3'd3,
        ST_PLAY       = 3'd4,
        ST_PLAY_PAUSE = 3'd5
    } aud_state_e;

    typedef enum logic {
        INTERP_CONST  = 1'b0,
        INTERP_LINEAR = 1'b1
    } aud_interp_e;

    // Speed code width is a module parameter, so the full speed-mode bundle
    // is declared in the top as {mode, speed}.
    typedef struct packed {
        logic        fast;
        aud_interp_e interp;
    } aud_mode_t;

endpackage

// File: rtl/aud_slot_len_table.sv
// Per-slot recorded-length register file: one write port, one read port,
// plus a per-slot "has data" flag used to reject playback of empty slots.
module aud_slot_len_table #(
    parameter int N_SLOTS = 4,
    parameter int LEN_W   = 19,
    localparam int SLOT_W = $clog2(N_SLOTS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              we,
    input  logic [SLOT_W-1:0] wr_slot,
    input  logic [LEN_W-1:0]  wr_len,
    input  logic [SLOT_W-1:0] rd_slot,
    output logic [LEN_W-1:0]  rd_len,
    output logic [N_SLOTS-1:0] used
);

    logic [LEN_W-1:0] len_q [N_SLOTS];

    // NOTE: this is a handful of flops, not a RAM macro, so it can and must be
    // reset; a reset mid-operation is defined to discard all recorded lengths.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                len_q[i] <= '0;
            end
        end else if (we) begin
            len_q[wr_slot] <= wr_len;
        end
    end

    assign rd_len = len_q[rd_slot];

    always_comb begin
        used = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            used[i] = |len_q[i];
        end
    end

endmodule

// File: rtl/aud_transport_ctrl.sv
// Audio transport controller: codec-init sequencing, record/play/pause/stop
// FSM with per-slot lengths, and SRAM address/ownership muxing.
module aud_transport_ctrl
    import aud_pkg::*;
#(
    parameter int ADDR_W     = 20,
    parameter int N_SLOTS    = 4,
    parameter int INIT_PULSE = INIT_PULSE_DEF,
    parameter int SPEED_W    = 4,
    localparam int SLOT_W    = $clog2(N_SLOTS),
    localparam int OFF_W     = ADDR_W - SLOT_W,
    localparam int LEN_W     = OFF_W + 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_key_rec,
    input  logic               i_key_play,
    input  logic               i_key_stop,
    input  logic [SLOT_W-1:0]  i_slot_sel,
    input  logic [SPEED_W-1:0] i_speed,
    input  logic               i_fast,
    input  logic               i_interp,
    input  logic               i_i2c_fin,
    input  logic [OFF_W-1:0]   i_rec_off,
    input  logic [OFF_W-1:0]   i_play_off,
    output logic               o_i2c_start,
    output logic               o_rec_start,
    output logic               o_rec_pause,
    output logic               o_rec_stop,
    output logic               o_dsp_start,
    output logic               o_dsp_pause,
    output logic               o_dsp_stop,
    output logic               o_play_en,
    output logic [SPEED_W-1:0] o_speed,
    output logic               o_fast,
    output logic               o_interp,
    output logic [ADDR_W-1:0]  o_sram_addr,
    output logic               o_sram_we_n,
    output logic               o_rec_owner,
    output logic [SLOT_W-1:0]  o_slot,
    output logic [LEN_W-1:0]   o_len,
    output logic [2:0]         o_state
);

    localparam int CNT_W = $clog2(INIT_PULSE + 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_PULSE);
    localparam logic [OFF_W-1:0] LAST_OFF  = {OFF_W{1'b1}};
    localparam logic [LEN_W-1:0] FULL_LEN  = {1'b1, {OFF_W{1'b0}}};

    typedef struct packed {
        aud_mode_t          mode;
        logic [SPEED_W-1:0] speed;
    } play_cfg_t;

    aud_state_e        state_q, state_d;
    logic [CNT_W-1:0]  init_cnt_q;
    logic [SLOT_W-1:0] slot_q, slot_d;
    play_cfg_t         cfg_q, cfg_d;
    logic              i2c_start_q, i2c_start_d;
    logic              rec_start_q, rec_start_d;
    logic              rec_pause_q, rec_pause_d;
    logic              rec_stop_q, rec_stop_d;
    logic              dsp_start_q, dsp_start_d;
    logic              dsp_pause_q, dsp_pause_d;
    logic              dsp_stop_q, dsp_stop_d;
    logic              play_en_q, play_en_d;
    logic              we_n_q, we_n_d;
    logic              owner_q, owner_d;

    logic               len_we;
    logic [LEN_W-1:0]   len_wdata;
    logic [LEN_W-1:0]   cur_len;
    logic [N_SLOTS-1:0] slot_used;

    // Coincident keys resolve stop > rec > play.
    logic key_stop, key_rec, key_play;
    assign key_stop = i_key_stop;
    assign key_rec  = i_key_rec & ~i_key_stop;
    assign key_play = i_key_play & ~i_key_stop & ~i_key_rec;

    logic slot_full, play_end;
    assign slot_full = (i_rec_off == LAST_OFF);
    assign play_end  = ({1'b0, i_play_off} >= cur_len);

    aud_slot_len_table #(
        .N_SLOTS (N_SLOTS),
        .LEN_W   (LEN_W)
    ) u_len_table (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .we      (len_we),
        .wr_slot (slot_q),
        .wr_len  (len_wdata),
        .rd_slot (slot_q),
        .rd_len  (cur_len),
        .used    (slot_used)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        cfg_d       = cfg_q;
        rec_start_d = 1'b0;
        rec_pause_d = 1'b0;
        rec_stop_d  = 1'b0;
        dsp_start_d = 1'b0;
        dsp_pause_d = 1'b0;
        dsp_stop_d  = 1'b0;
        len_we      = 1'b0;
        len_wdata   = '0;

        case (state_q)
            ST_INIT: begin
                if (i_i2c_fin) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (key_rec) begin
                    slot_d      = i_slot_sel;
                    rec_start_d = 1'b1;
                    state_d     = ST_RECD;
                end else if (key_play) begin
                    slot_d = i_slot_sel;
                    if (slot_used[i_slot_sel]) begin
                        cfg_d.speed       = i_speed;
                        cfg_d.mode.fast   = i_fast;
                        cfg_d.mode.interp = aud_interp_e'(i_interp);
                        dsp_start_d       = 1'b1;
                        state_d           = ST_PLAY;
                    end
                end
            end
            ST_RECD: begin
                if (slot_full) begin
                    rec_stop_d = 1'b1;
                    len_we     = 1'b1;
                    len_wdata  = FULL_LEN;
                    state_d    = ST_IDLE;
                end else if (key_stop) begin
                    rec_stop_d = 1'b1;
                    len_we     = 1'b1;
                    len_wdata  = {1'b0, i_rec_off};
                    state_d    = ST_IDLE;
                end else if (key_rec) begin
                    rec_pause_d = 1'b1;
                    state_d     = ST_RECD_PAUSE;
                end
            end
            ST_RECD_PAUSE: begin
                if (key_stop) begin
                    rec_stop_d = 1'b1;
                    len_we     = 1'b1;
                    len_wdata  = {1'b0, i_rec_off};
                    state_d    = ST_IDLE;
                end else if (key_rec) begin
                    rec_start_d = 1'b1;
                    state_d     = ST_RECD;
                end
            end
            ST_PLAY: begin
                if (play_end || key_stop) begin
                    dsp_stop_d = 1'b1;
                    state_d    = ST_IDLE;
                end else if (key_play) begin
                    dsp_pause_d = 1'b1;
                    state_d     = ST_PLAY_PAUSE;
                end
            end
            ST_PLAY_PAUSE: begin
                if (key_stop) begin
                    dsp_stop_d = 1'b1;
                    state_d    = ST_IDLE;
                end else if (key_play) begin
                    cfg_d.speed       = i_speed;
                    cfg_d.mode.fast   = i_fast;
                    cfg_d.mode.interp = aud_interp_e'(i_interp);
                    dsp_start_d       = 1'b1;
                    state_d           = ST_PLAY;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // Level outputs are decoded from the next state so they line up with
        // the registered state code.
        play_en_d   = (state_d == ST_PLAY);
        we_n_d      = (state_d != ST_RECD);
        owner_d     = (state_d == ST_RECD);
        i2c_start_d = (state_d == ST_INIT) && (init_cnt_q < INIT_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed above.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            slot_q      <= '0;
            cfg_q       <= '0;
            i2c_start_q <= 1'b0;
            rec_start_q <= 1'b0;
            rec_pause_q <= 1'b0;
            rec_stop_q  <= 1'b0;
            dsp_start_q <= 1'b0;
            dsp_pause_q <= 1'b0;
            dsp_stop_q  <= 1'b0;
            play_en_q   <= 1'b0;
            we_n_q      <= 1'b1;
            owner_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            cfg_q       <= cfg_d;
            i2c_start_q <= i2c_start_d;
            rec_start_q <= rec_start_d;
            rec_pause_q <= rec_pause_d;
            rec_stop_q  <= rec_stop_d;
            dsp_start_q <= dsp_start_d;
            dsp_pause_q <= dsp_pause_d;
            dsp_stop_q  <= dsp_stop_d;
            play_en_q   <= play_en_d;
            we_n_q      <= we_n_d;
            owner_q     <= owner_d;
            if (state_q == ST_INIT && init_cnt_q < INIT_LAST) begin
                init_cnt_q <= init_cnt_q + 1'b1;
            end
        end
    end

    assign o_state     = state_q;
    assign o_i2c_start = i2c_start_q;
    assign o_rec_start = rec_start_q;
    assign o_rec_pause = rec_pause_q;
    assign o_rec_stop  = rec_stop_q;
    assign o_dsp_start = dsp_start_q;
    assign o_dsp_pause = dsp_pause_q;
    assign o_dsp_stop  = dsp_stop_q;
    assign o_play_en   = play_en_q;
    assign o_speed     = cfg_q.speed;
    assign o_fast      = cfg_q.mode.fast;
    assign o_interp    = cfg_q.mode.interp;
    assign o_sram_we_n = we_n_q;
    assign o_rec_owner = owner_q;
    assign o_slot      = slot_q;
    assign o_len       = cur_len;

    // The only combinational output: the offset follows the owning engine.
    assign o_sram_addr = (state_q == ST_RECD || state_q == ST_RECD_PAUSE)
                       ? {slot_q, i_rec_off} : {slot_q, i_play_off};

endmodule

// File: tb/tb_aud_transport_ctrl.sv
// Directed bench for aud_transport_ctrl: init sequencing, record/pause/stop,
// slot-full auto-stop, playback with end-of-recording, pause/resume, reset.
module tb_aud_transport_ctrl;

    localparam int ADDR_W = 8;
    localparam int N_SLOTS = 4;
    localparam int INIT_PULSE = 16;
    localparam int SPEED_W = 4;
    localparam int SLOT_W = 2;
    localparam int OFF_W = 6;
    localparam int LEN_W = 7;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               key_rec = 1'b0, key_play = 1'b0, key_stop = 1'b0;
    logic [SLOT_W-1:0]  slot_sel = '0;
    logic [SPEED_W-1:0] speed = '0;
    logic               fast = 1'b0, interp = 1'b0, i2c_fin = 1'b0;
    logic [OFF_W-1:0]   rec_off = '0, play_off = '0;

    logic               i2c_start, rec_start, rec_pause, rec_stop;
    logic               dsp_start, dsp_pause, dsp_stop, play_en;
    logic [SPEED_W-1:0] o_speed;
    logic               o_fast, o_interp, sram_we_n, rec_owner;
    logic [ADDR_W-1:0]  sram_addr;
    logic [SLOT_W-1:0]  o_slot;
    logic [LEN_W-1:0]   o_len;
    logic [2:0]         o_state;

    int checks = 0;
    int failures = 0;

    wire [5:0] pulses = {rec_start, rec_pause, rec_stop, dsp_start, dsp_pause, dsp_stop};

    aud_transport_ctrl #(
        .ADDR_W(ADDR_W), .N_SLOTS(N_SLOTS), .INIT_PULSE(INIT_PULSE), .SPEED_W(SPEED_W)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_key_rec(key_rec), .i_key_play(key_play), .i_key_stop(key_stop),
        .i_slot_sel(slot_sel), .i_speed(speed), .i_fast(fast), .i_interp(interp),
        .i_i2c_fin(i2c_fin), .i_rec_off(rec_off), .i_play_off(play_off),
        .o_i2c_start(i2c_start), .o_rec_start(rec_start), .o_rec_pause(rec_pause),
        .o_rec_stop(rec_stop), .o_dsp_start(dsp_start), .o_dsp_pause(dsp_pause),
        .o_dsp_stop(dsp_stop), .o_play_en(play_en), .o_speed(o_speed),
        .o_fast(o_fast), .o_interp(o_interp), .o_sram_addr(sram_addr),
        .o_sram_we_n(sram_we_n), .o_rec_owner(rec_owner), .o_slot(o_slot),
        .o_len(o_len), .o_state(o_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic r, input logic p, input logic s);
        key_rec = r; key_play = p; key_stop = s;
        tick();
        key_rec = 1'b0; key_play = 1'b0; key_stop = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++; if (o_state !== 3'd0) begin failures++; $display("FAIL rst_state: got %0d want 0", o_state); end
        checks++; if (i2c_start !== 1'b0) begin failures++; $display("FAIL rst_i2c: got %b want 0", i2c_start); end
        checks++; if (pulses !== 6'b0) begin failures++; $display("FAIL rst_pulses: got %b want 000000", pulses); end
        checks++; if ({play_en, rec_owner, sram_we_n} !== 3'b001) begin failures++; $display("FAIL rst_levels: got %b want 001", {play_en, rec_owner, sram_we_n}); end
        checks++; if ({o_speed, o_fast, o_interp, o_slot, o_len} !== '0) begin failures++; $display("FAIL rst_latched: got %h want 0", {o_speed, o_fast, o_interp, o_slot, o_len}); end
    endtask

    task automatic test_init();
        int high_cnt = 0;
        bit saw_pulse = 1'b0;
        rst_n = 1'b1;
        for (int cyc = 1; cyc <= 21; cyc++) begin
            key_rec  = (cyc >= 5 && cyc <= 19 && cyc % 3 == 0);
            key_play = (cyc >= 5 && cyc <= 19 && cyc % 3 == 1);
            key_stop = (cyc >= 5 && cyc <= 19 && cyc % 3 == 2);
            i2c_fin  = (cyc >= 21);
            tick();
            if (i2c_start) high_cnt++;
            if (pulses != 6'b0) saw_pulse = 1'b1;
            checks++; if (i2c_start !== (cyc <= 16)) begin failures++; $display("FAIL init_i2c cyc %0d: got %b want %b", cyc, i2c_start, cyc <= 16); end
            checks++; if (o_state !== ((cyc >= 21) ? 3'd1 : 3'd0)) begin failures++; $display("FAIL init_state cyc %0d: got %0d", cyc, o_state); end
        end
        key_rec = 1'b0; key_play = 1'b0; key_stop = 1'b0;
        checks++; if (high_cnt != 16) begin failures++; $display("FAIL init_pulse_len: got %0d want 16", high_cnt); end
        checks++; if (saw_pulse) begin failures++; $display("FAIL init_keys_ignored: a command pulse appeared in INIT"); end
    endtask

    task automatic test_record_stop();
        slot_sel = 2'd2; rec_off = '0;
        press(1, 0, 0);
        checks++; if (o_state !== 3'd2) begin failures++; $display("FAIL rec_state: got %0d want 2", o_state); end
        checks++; if ({rec_start, sram_we_n, rec_owner} !== 3'b101) begin failures++; $display("FAIL rec_start: got %b want 101", {rec_start, sram_we_n, rec_owner}); end
        rec_off = 6'd37; slot_sel = 2'd0;
        #1;
        checks++; if (sram_addr !== 8'hA5) begin failures++; $display("FAIL rec_addr: got %h want a5", sram_addr); end
        tick();
        checks++; if ({rec_start, sram_we_n, o_slot} !== {1'b0, 1'b0, 2'd2}) begin failures++; $display("FAIL rec_hold: got %b want 0010", {rec_start, sram_we_n, o_slot}); end
        press(0, 0, 1);
        checks++; if ({rec_stop, o_state} !== {1'b1, 3'd1}) begin failures++; $display("FAIL rec_stop: got %b want 1001", {rec_stop, o_state}); end
        checks++; if (o_len !== 7'd37) begin failures++; $display("FAIL rec_len: got %0d want 37", o_len); end
        checks++; if ({sram_we_n, rec_owner} !== 2'b10) begin failures++; $display("FAIL rec_release: got %b want 10", {sram_we_n, rec_owner}); end
        tick();
        checks++; if (rec_stop !== 1'b0) begin failures++; $display("FAIL rec_stop_width: got %b want 0", rec_stop); end
    endtask

    task automatic test_pause_and_full();
        slot_sel = 2'd1; rec_off = '0;
        press(1, 0, 0);
        press(1, 0, 0);
        checks++; if ({o_state, rec_pause, sram_we_n, rec_owner} !== {3'd3, 1'b1, 1'b1, 1'b0}) begin failures++; $display("FAIL rec_pause: got %b want 011110", {o_state, rec_pause, sram_we_n, rec_owner}); end
        rec_off = 6'd5;
        #1;
        checks++; if (sram_addr !== 8'h45) begin failures++; $display("FAIL pause_addr: got %h want 45", sram_addr); end
        press(1, 0, 0);
        checks++; if ({o_state, rec_start, rec_pause} !== {3'd2, 1'b1, 1'b0}) begin failures++; $display("FAIL rec_resume: got %b want 01010", {o_state, rec_start, rec_pause}); end
        for (int v = 60; v <= 62; v++) begin
            rec_off = OFF_W'(v);
            tick();
        end
        checks++; if (o_state !== 3'd2) begin failures++; $display("FAIL ramp_state: got %0d want 2", o_state); end
        rec_off = 6'd63;
        press(1, 0, 0);
        checks++; if ({o_state, rec_stop, rec_pause} !== {3'd1, 1'b1, 1'b0}) begin failures++; $display("FAIL full_stop: got %b want 00110", {o_state, rec_stop, rec_pause}); end
        checks++; if (o_len !== 7'd64) begin failures++; $display("FAIL full_len: got %0d want 64", o_len); end
        rec_off = '0;
    endtask

    task automatic test_play();
        slot_sel = 2'd2; speed = 4'd3; fast = 1'b1; interp = 1'b0; play_off = '0;
        press(0, 1, 0);
        checks++; if ({o_state, dsp_start, play_en} !== {3'd4, 1'b1, 1'b1}) begin failures++; $display("FAIL play_start: got %b want 10011", {o_state, dsp_start, play_en}); end
        checks++; if ({o_speed, o_fast, o_interp} !== {4'd3, 1'b1, 1'b0}) begin failures++; $display("FAIL play_cfg: got %b want 001110", {o_speed, o_fast, o_interp}); end
        checks++; if ({o_len, sram_addr} !== {7'd37, 8'h80}) begin failures++; $display("FAIL play_len_addr: got %0d/%h want 37/80", o_len, sram_addr); end
        play_off = 6'd36;
        tick();
        checks++; if ({o_state, dsp_start} !== {3'd4, 1'b0}) begin failures++; $display("FAIL play_run: got %b want 1000", {o_state, dsp_start}); end
        play_off = 6'd37;
        tick();
        checks++; if ({o_state, dsp_stop, play_en} !== {3'd1, 1'b1, 1'b0}) begin failures++; $display("FAIL play_end: got %b want 00110", {o_state, dsp_stop, play_en}); end
        tick();
        checks++; if (dsp_stop !== 1'b0) begin failures++; $display("FAIL play_end_width: got %b want 0", dsp_stop); end
        play_off = '0;
    endtask

    task automatic test_play_empty();
        slot_sel = 2'd3;
        press(0, 1, 0);
        checks++; if ({o_state, play_en, pulses} !== {3'd1, 1'b0, 6'b0}) begin failures++; $display("FAIL empty_play: got %b want 0010000000", {o_state, play_en, pulses}); end
        checks++; if ({o_slot, o_len} !== {2'd3, 7'd0}) begin failures++; $display("FAIL empty_slot: got %0d/%0d want 3/0", o_slot, o_len); end
    endtask

    task automatic test_pause_resume();
        slot_sel = 2'd2; speed = 4'd3; play_off = '0;
        press(0, 1, 0);
        press(0, 1, 0);
        checks++; if ({o_state, dsp_pause, dsp_start, play_en} !== {3'd5, 1'b1, 1'b0, 1'b0}) begin failures++; $display("FAIL play_pause: got %b want 101100", {o_state, dsp_pause, dsp_start, play_en}); end
        speed = 4'd5; interp = 1'b1;
        press(0, 1, 0);
        checks++; if ({o_state, dsp_start, play_en, o_speed, o_interp} !== {3'd4, 1'b1, 1'b1, 4'd5, 1'b1}) begin failures++; $display("FAIL play_resume: got %b want 100110101", {o_state, dsp_start, play_en, o_speed, o_interp}); end
        press(0, 1, 1);
        checks++; if ({o_state, dsp_stop, dsp_pause, play_en} !== {3'd1, 1'b1, 1'b0, 1'b0}) begin failures++; $display("FAIL stop_prio: got %b want 001100", {o_state, dsp_stop, dsp_pause, play_en}); end
    endtask

    task automatic test_reset_mid_play();
        slot_sel = 2'd2; play_off = '0;
        press(0, 1, 0);
        checks++; if (o_state !== 3'd4) begin failures++; $display("FAIL mid_pre: got %0d want 4", o_state); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({o_state, play_en, pulses, i2c_start} !== 11'b0) begin failures++; $display("FAIL mid_rst_ctrl: got %b want 0", {o_state, play_en, pulses, i2c_start}); end
        checks++; if ({o_speed, o_fast, o_interp, o_slot, sram_we_n, rec_owner} !== {9'b0, 1'b1, 1'b0}) begin failures++; $display("FAIL mid_rst_latched: got %b", {o_speed, o_fast, o_interp, o_slot, sram_we_n, rec_owner}); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (o_state !== 3'd1) begin failures++; $display("FAIL mid_reinit: got %0d want 1", o_state); end
        slot_sel = 2'd2;
        press(0, 1, 0);
        checks++; if ({o_state, dsp_start, o_len} !== {3'd1, 1'b0, 7'd0}) begin failures++; $display("FAIL mid_len_lost: got state %0d start %b len %0d", o_state, dsp_start, o_len); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_record_stop();
        test_pause_and_full();
        test_play();
        test_play_empty();
        test_pause_resume();
        test_reset_mid_play();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
